mem_arbiter: RTL and testbench

- Shares one single-outstanding memory port between the instruction-fetch requester (IF) and the load/store requester (LS) of the 5-stage pipeline.
- Fixed priority goes to LS, with a starvation counter that guarantees IF forward progress.
- Registers the winning request, drives the downstream memory handshake, then routes the response back to the owner.
- Sits between IF_stage/ls_stage and the unified memory/bus bridge.

---
 rtl/mem_arbiter_pkg.sv | 18 +
 rtl/mem_arbiter_arb_prio_sel.sv | 42 ++++
 rtl/mem_arbiter.sv | 124 ++++++++++++
 tb/tb_mem_arbiter.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared encodings and constants for the IF/LS memory arbiter.
package mem_arbiter_pkg;

  localparam int MASK_W = 8;
  localparam int CNT_W  = 4;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_REQ  = 2'd1,
    ARB_RESP = 2'd2
  } arb_state_e;

  typedef enum logic {
    ARB_OWN_IF = 1'b0,
    ARB_OWN_LS = 1'b1
  } arb_owner_e;

endpackage

// File: rtl/mem_arbiter_arb_prio_sel.sv
// Winner selection between IF and LS: LS has fixed priority, but after
// STARVE_MAX consecutive contested LS wins the next contention goes to IF.
module arb_prio_sel
  import mem_arbiter_pkg::*;
#(
  parameter int STARVE_MAX = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic if_valid,
  input  logic ls_valid,
  input  logic idle,
  output logic grant_if,
  output logic grant_ls
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

  logic [CNT_W-1:0] r_starve_cnt;
  logic             w_starved;
  logic             w_contend;

  // Grants are only issued in IDLE; IF overrides LS once it has starved.
  always_comb begin
    w_starved = (r_starve_cnt == CNT_MAX);
    w_contend = if_valid && ls_valid;
    grant_if  = idle && if_valid && (!ls_valid || w_starved);
    grant_ls  = idle && ls_valid && !(if_valid && w_starved);
  end

  // Count contested LS wins (saturating); any IF acceptance clears the count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_starve_cnt <= '0;
    end else if (grant_if) begin
      r_starve_cnt <= '0;
    end else if (grant_ls && w_contend && !w_starved) begin
      r_starve_cnt <= r_starve_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one single-outstanding memory port between instruction fetch and
// load/store: latches the winning request, drives the downstream handshake
// and routes the response back to whichever requester owns the transaction.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int XLEN       = 64,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req_valid,
  output logic              if_req_ready,
  input  logic [XLEN-1:0]   if_addr,
  output logic              if_rsp_valid,
  output logic [XLEN-1:0]   if_rdata,
  input  logic              ls_req_valid,
  output logic              ls_req_ready,
  input  logic [XLEN-1:0]   ls_addr,
  input  logic              ls_wen,
  input  logic [XLEN-1:0]   ls_wdata,
  input  logic [MASK_W-1:0] ls_wmask,
  output logic              ls_rsp_valid,
  output logic [XLEN-1:0]   ls_rdata,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic [XLEN-1:0]   mem_addr,
  output logic              mem_wen,
  output logic [XLEN-1:0]   mem_wdata,
  output logic [MASK_W-1:0] mem_wmask,
  input  logic              mem_rsp_valid,
  input  logic [XLEN-1:0]   mem_rdata,
  output logic              busy
);

  arb_state_e        r_state;
  arb_state_e        w_state_nxt;
  arb_owner_e        r_owner;
  logic [XLEN-1:0]   r_addr;
  logic              r_wen;
  logic [XLEN-1:0]   r_wdata;
  logic [MASK_W-1:0] r_wmask;

  logic w_idle;
  logic w_grant_if;
  logic w_grant_ls;
  logic w_rsp_fire;

  // rst_n gating keeps the combinational readies at 0 while reset is held.
  assign w_idle = (r_state == ARB_IDLE) && rst_n;

  arb_prio_sel #(
    .STARVE_MAX (STARVE_MAX)
  ) u_prio_sel (
    .clk      (clk),
    .rst_n    (rst_n),
    .if_valid (if_req_valid),
    .ls_valid (ls_req_valid),
    .idle     (w_idle),
    .grant_if (w_grant_if),
    .grant_ls (w_grant_ls)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ARB_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic; a response outside RESP is ignored.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ARB_IDLE: if (w_grant_if || w_grant_ls) w_state_nxt = ARB_REQ;
      ARB_REQ:  if (mem_req_ready)            w_state_nxt = ARB_RESP;
      ARB_RESP: if (mem_rsp_valid)            w_state_nxt = ARB_IDLE;
      default:                                w_state_nxt = ARB_IDLE;
    endcase
  end

  // Request latch: capture the winner's request and remember who owns it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_owner <= ARB_OWN_IF;
      r_addr  <= '0;
      r_wen   <= 1'b0;
      r_wdata <= '0;
      r_wmask <= '0;
    end else if (w_grant_if) begin
      r_owner <= ARB_OWN_IF;
      r_addr  <= if_addr;
      r_wen   <= 1'b0;
      r_wdata <= '0;
      r_wmask <= '0;
    end else if (w_grant_ls) begin
      r_owner <= ARB_OWN_LS;
      r_addr  <= ls_addr;
      r_wen   <= ls_wen;
      r_wdata <= ls_wdata;
      r_wmask <= ls_wmask;
    end
  end

  // Handshake outputs and response routing to the owner only.
  always_comb begin
    w_rsp_fire    = (r_state == ARB_RESP) && mem_rsp_valid;
    if_req_ready  = w_grant_if;
    ls_req_ready  = w_grant_ls;
    mem_req_valid = (r_state == ARB_REQ);
    mem_addr      = r_addr;
    mem_wen       = r_wen;
    mem_wdata     = r_wdata;
    mem_wmask     = r_wmask;
    if_rsp_valid  = w_rsp_fire && (r_owner == ARB_OWN_IF);
    ls_rsp_valid  = w_rsp_fire && (r_owner == ARB_OWN_LS);
    if_rdata      = if_rsp_valid ? mem_rdata : '0;
    ls_rdata      = ls_rsp_valid ? mem_rdata : '0;
    busy          = (r_state != ARB_IDLE);
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: fetch, store, contention/starvation,
// backpressure, stray response and mid-transaction reset.
module tb_mem_arbiter;

  localparam int XLEN = 64;

  logic            clk;
  logic            rst_n;
  logic            if_req_valid;
  logic            if_req_ready;
  logic [XLEN-1:0] if_addr;
  logic            if_rsp_valid;
  logic [XLEN-1:0] if_rdata;
  logic            ls_req_valid;
  logic            ls_req_ready;
  logic [XLEN-1:0] ls_addr;
  logic            ls_wen;
  logic [XLEN-1:0] ls_wdata;
  logic [7:0]      ls_wmask;
  logic            ls_rsp_valid;
  logic [XLEN-1:0] ls_rdata;
  logic            mem_req_valid;
  logic            mem_req_ready;
  logic [XLEN-1:0] mem_addr;
  logic            mem_wen;
  logic [XLEN-1:0] mem_wdata;
  logic [7:0]      mem_wmask;
  logic            mem_rsp_valid;
  logic [XLEN-1:0] mem_rdata;
  logic            busy;

  int n_chk;
  int n_err;

  mem_arbiter #(
    .XLEN       (XLEN),
    .STARVE_MAX (4)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .if_req_valid  (if_req_valid),
    .if_req_ready  (if_req_ready),
    .if_addr       (if_addr),
    .if_rsp_valid  (if_rsp_valid),
    .if_rdata      (if_rdata),
    .ls_req_valid  (ls_req_valid),
    .ls_req_ready  (ls_req_ready),
    .ls_addr       (ls_addr),
    .ls_wen        (ls_wen),
    .ls_wdata      (ls_wdata),
    .ls_wmask      (ls_wmask),
    .ls_rsp_valid  (ls_rsp_valid),
    .ls_rdata      (ls_rdata),
    .mem_req_valid (mem_req_valid),
    .mem_req_ready (mem_req_ready),
    .mem_addr      (mem_addr),
    .mem_wen       (mem_wen),
    .mem_wdata     (mem_wdata),
    .mem_wmask     (mem_wmask),
    .mem_rsp_valid (mem_rsp_valid),
    .mem_rdata     (mem_rdata),
    .busy          (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    bit         exp_if  [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    logic [3:0] exp_cnt [6] = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd0, 4'd1};

    n_chk = 0;
    n_err = 0;

    // Reset with requests and a response asserted: outputs must stay 0.
    rst_n         = 1'b0;
    if_req_valid  = 1'b1;
    if_addr       = 64'h1234;
    ls_req_valid  = 1'b1;
    ls_addr       = 64'h5678;
    ls_wen        = 1'b1;
    ls_wdata      = 64'h0;
    ls_wmask      = 8'h0;
    mem_req_ready = 1'b1;
    mem_rsp_valid = 1'b1;
    mem_rdata     = 64'hFFFF;
    tick();
    tick();
    chk("rst_if_ready", if_req_ready, 1'b0);
    chk("rst_ls_ready", ls_req_ready, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_mem_valid", mem_req_valid, 1'b0);
    chk("rst_mem_addr", mem_addr, 64'h0);
    chk("rst_if_rsp", if_rsp_valid, 1'b0);
    chk("rst_ls_rsp", ls_rsp_valid, 1'b0);
    chk("rst_starve", dut.u_prio_sel.r_starve_cnt, 4'd0);
    if_req_valid  = 1'b0;
    ls_req_valid  = 1'b0;
    mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b0;
    rst_n         = 1'b1;
    tick();

    // IF-only fetch with zero-wait memory.
    if_req_valid = 1'b1;
    if_addr      = 64'h0000_0000_8000_0000;
    #1;
    chk("if_ready_N", if_req_ready, 1'b1);
    chk("ls_ready_N", ls_req_ready, 1'b0);
    tick();
    if_req_valid  = 1'b0;
    mem_req_ready = 1'b1;
    #1;
    chk("if_memvalid_N1", mem_req_valid, 1'b1);
    chk("if_memaddr", mem_addr, 64'h0000_0000_8000_0000);
    chk("if_memwen", mem_wen, 1'b0);
    chk("if_memwmask", mem_wmask, 8'h00);
    tick();
    mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b1;
    mem_rdata     = 64'h0000_0000_0000_0013;
    #1;
    chk("if_memvalid_N2", mem_req_valid, 1'b0);
    chk("if_rsp_valid", if_rsp_valid, 1'b1);
    chk("if_rdata", if_rdata, 64'h13);
    chk("if_ls_rsp", ls_rsp_valid, 1'b0);
    tick();
    mem_rsp_valid = 1'b0;
    #1;
    chk("if_done_busy", busy, 1'b0);
    chk("if_rsp_drop", if_rsp_valid, 1'b0);

    // LS store.
    ls_req_valid = 1'b1;
    ls_addr      = 64'h0000_0000_8000_1000;
    ls_wen       = 1'b1;
    ls_wdata     = 64'h0000_0000_DEAD_BEEF;
    ls_wmask     = 8'h0F;
    #1;
    chk("st_ls_ready", ls_req_ready, 1'b1);
    chk("st_if_ready", if_req_ready, 1'b0);
    tick();
    ls_req_valid  = 1'b0;
    ls_wdata      = 64'h0;
    mem_req_ready = 1'b1;
    #1;
    chk("st_memaddr", mem_addr, 64'h0000_0000_8000_1000);
    chk("st_memwen", mem_wen, 1'b1);
    chk("st_memwdata", mem_wdata, 64'h0000_0000_DEAD_BEEF);
    chk("st_memwmask", mem_wmask, 8'h0F);
    tick();
    mem_req_ready = 1'b0;
    #1;
    chk("st_no_early_ack", ls_rsp_valid, 1'b0);
    tick();
    chk("st_wait_busy", busy, 1'b1);
    mem_rsp_valid = 1'b1;
    mem_rdata     = 64'h0;
    #1;
    chk("st_ack", ls_rsp_valid, 1'b1);
    chk("st_if_rsp", if_rsp_valid, 1'b0);
    tick();
    mem_rsp_valid = 1'b0;

    // Contention: LS x4, then IF, then LS again.
    if_req_valid = 1'b1;
    if_addr      = 64'hA000;
    ls_req_valid = 1'b1;
    ls_addr      = 64'hB000;
    ls_wen       = 1'b0;
    for (int i = 0; i < 6; i++) begin
      #1;
      chk($sformatf("ct_if_ready%0d", i), if_req_ready, exp_if[i]);
      chk($sformatf("ct_ls_ready%0d", i), ls_req_ready, !exp_if[i]);
      tick();
      chk($sformatf("ct_starve%0d", i), dut.u_prio_sel.r_starve_cnt, exp_cnt[i]);
      chk($sformatf("ct_addr%0d", i), mem_addr, exp_if[i] ? 64'hA000 : 64'hB000);
      mem_req_ready = 1'b1;
      tick();
      mem_req_ready = 1'b0;
      mem_rsp_valid = 1'b1;
      mem_rdata     = 64'(i + 100);
      #1;
      chk($sformatf("ct_if_rsp%0d", i), if_rsp_valid, exp_if[i]);
      chk($sformatf("ct_ls_rsp%0d", i), ls_rsp_valid, !exp_if[i]);
      tick();
      mem_rsp_valid = 1'b0;
    end
    if_req_valid = 1'b0;
    ls_req_valid = 1'b0;
    tick();

    // Backpressure: address held while the memory stalls.
    ls_req_valid = 1'b1;
    ls_addr      = 64'h0000_0000_8000_2000;
    ls_wen       = 1'b0;
    #1;
    chk("bp_accept", ls_req_ready, 1'b1);
    tick();
    for (int i = 0; i < 5; i++) begin
      ls_addr      = 64'h1111_0000 + 64'(i);
      if_req_valid = 1'b1;
      #1;
      chk($sformatf("bp_addr%0d", i), mem_addr, 64'h0000_0000_8000_2000);
      chk($sformatf("bp_valid%0d", i), mem_req_valid, 1'b1);
      chk($sformatf("bp_lsrdy%0d", i), ls_req_ready, 1'b0);
      chk($sformatf("bp_ifrdy%0d", i), if_req_ready, 1'b0);
      chk($sformatf("bp_busy%0d", i), busy, 1'b1);
      tick();
    end
    if_req_valid  = 1'b0;
    ls_req_valid  = 1'b0;
    mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b1;
    mem_rdata     = 64'h55;
    #1;
    chk("bp_rsp", ls_rsp_valid, 1'b1);
    chk("bp_rdata", ls_rdata, 64'h55);
    chk("bp_if_rdata", if_rdata, 64'h0);
    tick();
    mem_rsp_valid = 1'b0;

    // Stray response in IDLE.
    mem_rsp_valid = 1'b1;
    mem_rdata     = 64'h77;
    #1;
    chk("stray_if_rsp", if_rsp_valid, 1'b0);
    chk("stray_ls_rsp", ls_rsp_valid, 1'b0);
    tick();
    mem_rsp_valid = 1'b0;
    #1;
    chk("stray_busy", busy, 1'b0);

    // Reset while in RESP.
    if_req_valid = 1'b1;
    if_addr      = 64'hC000;
    tick();
    if_req_valid  = 1'b0;
    mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0;
    #1;
    chk("mr_in_resp", busy, 1'b1);
    if_req_valid  = 1'b1;
    ls_req_valid  = 1'b1;
    mem_rsp_valid = 1'b1;
    rst_n         = 1'b0;
    #1;
    chk("mr_busy", busy, 1'b0);
    chk("mr_if_rsp", if_rsp_valid, 1'b0);
    chk("mr_if_rdata", if_rdata, 64'h0);
    chk("mr_if_ready", if_req_ready, 1'b0);
    chk("mr_ls_ready", ls_req_ready, 1'b0);
    chk("mr_mem_addr", mem_addr, 64'h0);
    tick();
    if_req_valid = 1'b0;
    ls_req_valid = 1'b0;
    rst_n        = 1'b1;
    #1;
    chk("mr_late_rsp", if_rsp_valid, 1'b0);
    chk("mr_idle", busy, 1'b0);
    tick();
    mem_rsp_valid = 1'b0;
    #1;
    chk("mr_idle_after", busy, 1'b0);
    chk("mr_memvalid_after", mem_req_valid, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
